uart_rx_pkt_ctrl: RTL and testbench

Sequencer sitting directly downstream of the UART receiver (50 MHz clk, 115200 baud, 8-bit bytes).
- Drives the receiver's rxEn.
- Consumes each rxDone/out_data byte and parses a framed packet: SYNC, LEN, payload, CHK.
- Holds the payload in an internal buffer and releases it over a valid/ready stream only after the checksum passes.
- Reports length, checksum and inter-byte timeout errors.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_pkt_buf.sv | 35 +++
 rtl/uart_rx_pkt_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared encodings and defaults for the UART packet receive path.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int BAUD            = 115200;
  localparam int BIT_CYC         = CLK_HZ / BAUD;
  // Ten byte times of ten bit periods each.
  localparam int DEF_TIMEOUT_CYC = 100 * BIT_CYC;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_W_SYNC  = 3'd1;
  localparam logic [2:0] ST_W_LEN   = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_W_CHK   = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  function automatic logic rx_active(input logic [2:0] st);
    return (st == ST_W_SYNC) || (st == ST_W_LEN) || (st == ST_PAYLOAD) || (st == ST_W_CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkt_buf
// Brief   : Payload register array, one write port, combinational read port.
// Revision: 1.0 - initial release
// ============================================================================
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wp,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] rp,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[wp] <= wdata;
    end
  end

  assign rdata = r_mem[rp];

endmodule
`default_nettype wire

// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_pkt_ctrl
// Brief   : Parses SYNC/LEN/payload/CHK frames from a UART receiver and
//           streams the payload out once the checksum matches.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rxDone,
  input  logic       rxBusy,
  input  logic [7:0] rx_byte,
  output logic       rxEn,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code
);

  localparam int              c_PW       = $clog2(MAX_LEN + 1);
  localparam int              c_AW       = $clog2(MAX_LEN);
  localparam int              c_TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      c_MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [c_TW-1:0] c_TMO      = c_TW'(TIMEOUT_CYC);

  logic [2:0]      r_state, w_next;
  logic [c_PW-1:0] r_len, r_wp, r_rp;
  logic [7:0]      r_sum;
  logic [c_TW-1:0] r_timer;
  logic            r_rx_en, r_pkt_ok, r_pkt_err;
  logic [1:0]      r_err_code;

  logic            w_timed, w_tmo, w_len_bad, w_wp_last, w_rp_last, w_xfer_last;
  logic            w_we, w_ok, w_err;
  logic [1:0]      w_code;
  logic [7:0]      w_rdata;

  assign w_timed     = (r_state == ST_W_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_W_CHK);
  // A byte landing in the same cycle as expiry wins over the timeout.
  assign w_tmo       = w_timed && !rxDone && (r_timer >= c_TMO);
  assign w_len_bad   = (rx_byte == 8'd0) || (rx_byte > c_MAX_LEN8);
  assign w_wp_last   = ((r_wp + c_PW'(1)) == r_len);
  assign w_rp_last   = (r_rp == (r_len - c_PW'(1)));
  assign w_xfer_last = (r_state == ST_DRAIN) && m_ready && w_rp_last;

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (c_AW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .wp    (r_wp[c_AW-1:0]),
    .wdata (rx_byte),
    .rp    (r_rp[c_AW-1:0]),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_next = ST_W_SYNC;
      end
      ST_W_SYNC: begin
        if (!enable)                              w_next = ST_IDLE;
        else if (rxDone && rx_byte == SYNC_BYTE)  w_next = ST_W_LEN;
      end
      ST_W_LEN: begin
        if (!enable)     w_next = ST_IDLE;
        else if (rxDone) w_next = w_len_bad ? ST_W_SYNC : ST_PAYLOAD;
        else if (w_tmo)  w_next = ST_W_SYNC;
      end
      ST_PAYLOAD: begin
        if (!enable)                  w_next = ST_IDLE;
        else if (rxDone && w_wp_last) w_next = ST_W_CHK;
        else if (w_tmo)               w_next = ST_W_SYNC;
      end
      ST_W_CHK: begin
        if (!enable)     w_next = ST_IDLE;
        else if (rxDone) w_next = (rx_byte == r_sum) ? ST_DRAIN : ST_W_SYNC;
        else if (w_tmo)  w_next = ST_W_SYNC;
      end
      ST_DRAIN: begin
        if (w_xfer_last) w_next = enable ? ST_W_SYNC : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_ok    = 1'b0;
    w_err   = 1'b0;
    w_code  = 2'd0;
    m_valid = (r_state == ST_DRAIN);
    m_data  = m_valid ? w_rdata : 8'd0;
    m_last  = m_valid && w_rp_last;
    if (enable) begin
      case (r_state)
        ST_W_LEN: begin
          if (rxDone && w_len_bad) begin
            w_err  = 1'b1;
            w_code = ERR_LEN;
          end else if (w_tmo) begin
            w_err  = 1'b1;
            w_code = ERR_TMO;
          end
        end
        ST_PAYLOAD: begin
          if (rxDone) begin
            w_we = 1'b1;
          end else if (w_tmo) begin
            w_err  = 1'b1;
            w_code = ERR_TMO;
          end
        end
        ST_W_CHK: begin
          if (rxDone) begin
            w_ok   = (rx_byte == r_sum);
            w_err  = (rx_byte != r_sum);
            w_code = (rx_byte != r_sum) ? ERR_CHK : 2'd0;
          end else if (w_tmo) begin
            w_err  = 1'b1;
            w_code = ERR_TMO;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_en    <= 1'b0;
      r_pkt_ok   <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_err_code <= 2'd0;
      r_len      <= '0;
      r_sum      <= 8'd0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_timer    <= '0;
    end else begin
      r_rx_en    <= rx_active(w_next);
      r_pkt_ok   <= w_ok;
      r_pkt_err  <= w_err;
      r_err_code <= w_code;
      if (r_state == ST_W_LEN && rxDone && !w_len_bad) begin
        r_len <= rx_byte[c_PW-1:0];
        r_sum <= rx_byte;
        r_wp  <= '0;
      end
      if (w_we) begin
        r_sum <= r_sum + rx_byte;
        r_wp  <= r_wp + c_PW'(1);
      end
      if (w_ok) begin
        r_rp <= '0;
      end else if (m_valid && m_ready) begin
        r_rp <= r_rp + c_PW'(1);
      end
      if (!w_timed || rxDone || (w_next != r_state)) begin
        r_timer <= '0;
      end else if (!rxBusy && (r_timer < c_TMO)) begin
        r_timer <= r_timer + c_TW'(1);
      end
    end
  end

  assign rxEn     = r_rx_en;
  assign pkt_ok   = r_pkt_ok;
  assign pkt_err  = r_pkt_err;
  assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_pkt_ctrl
// Brief   : Self-checking bench for uart_rx_pkt_ctrl (vector table + scoreboard).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rxDone = 1'b0;
  logic       rxBusy = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       m_ready = 1'b0;
  logic       rxEn, m_valid, m_last, pkt_ok, pkt_err;
  logic [7:0] m_data;
  logic [1:0] err_code;

  always #10 clk = ~clk;

  uart_rx_pkt_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .rxDone   (rxDone),
    .rxBusy   (rxBusy),
    .rx_byte  (rx_byte),
    .rxEn     (rxEn),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .pkt_ok   (pkt_ok),
    .pkt_err  (pkt_err),
    .err_code (err_code)
  );

  // code: 0 = packet accepted, otherwise the expected err_code.
  // off/np: index of the first payload byte within b, and payload length.
  typedef struct {
    int           nb;
    logic [159:0] b;
    int           code;
    int           off;
    int           np;
  } vec_t;

  vec_t vecs [8];
  int   q_evt [$];
  int   q_dat [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] vbyte(input vec_t v, input int k);
    return v.b[159 - 8*k -: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rxBusy = 1'b1;
    tick();
    tick();
    rxBusy  = 1'b0;
    rx_byte = b;
    rxDone  = 1'b1;
    tick();
    rxDone = 1'b0;
    tick();
    tick();
  endtask

  // Events: 0 = pkt_ok, 10+code = pkt_err with that err_code.
  task automatic push_expect(input vec_t v);
    if (v.code == 0) begin
      for (int k = 0; k < v.np; k++) begin
        q_dat.push_back(int'({(k == v.np - 1), vbyte(v, v.off + k)}));
      end
      q_evt.push_back(0);
    end else begin
      q_evt.push_back(10 + v.code);
    end
  endtask

  task automatic send_vec(input vec_t v);
    for (int k = 0; k < v.nb; k++) send_byte(vbyte(v, k));
  endtask

  task automatic wait_settle(input string name);
    int k;
    k = 0;
    while ((!rxEn || m_valid) && k < 60) begin
      tick();
      k++;
    end
    check(name, int'(rxEn && !m_valid), 1);
  endtask

  logic       prev_stall = 1'b0;
  logic       prev_last  = 1'b0;
  logic [8:0] prev_out   = 9'd0;

  always @(negedge clk) begin : mon
    int exp_v;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_last  = 1'b0;
    end else begin
      if (pkt_ok || pkt_err) begin
        exp_v = -1;
        if (q_evt.size() != 0) exp_v = q_evt.pop_front();
        check("pkt_event", pkt_ok ? (pkt_err ? 99 : 0) : 10 + int'(err_code), exp_v);
      end
      if (!pkt_err && err_code != 2'd0) check("err_code_idle", int'(err_code), 0);
      if (m_valid) check("rxEn_in_drain", int'(rxEn), 0);
      if (prev_stall) check("hold_stable", int'({m_valid, m_last, m_data}), int'({1'b1, prev_out}));
      if (prev_last && enable) check("rxEn_after_last", int'(rxEn), 1);
      if (m_valid && m_ready) begin
        exp_v = -1;
        if (q_dat.size() != 0) exp_v = q_dat.pop_front();
        check("stream_beat", int'({m_last, m_data}), exp_v);
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_last, m_data};
      prev_last  = m_valid && m_ready && m_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{6,  {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69, {14{8'h00}}}, 0, 2, 3};
    vecs[1] = '{5,  {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, {15{8'h00}}}, 2, 2, 0};
    vecs[2] = '{4,  {8'hA5, 8'h01, 8'h7F, 8'h80, {16{8'h00}}}, 0, 2, 1};
    vecs[3] = '{2,  {8'hA5, 8'h00, {18{8'h00}}}, 1, 2, 0};
    vecs[4] = '{2,  {8'hA5, 8'h11, {18{8'h00}}}, 1, 2, 0};
    vecs[5] = '{6,  {8'h55, 8'hAA, 8'hA5, 8'h01, 8'h00, 8'h01, {14{8'h00}}}, 0, 4, 1};
    vecs[6] = '{19, {8'hA5, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                     8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h98, 8'h00}, 0, 2, 16};
    vecs[7] = '{7,  {8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h3C, {13{8'h00}}}, 0, 2, 4};

    #35;
    check("reset_outputs", int'({rxEn, m_valid, m_last, pkt_ok, pkt_err, err_code, m_data}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_rxEn", int'(rxEn), 0);
    enable = 1'b1;
    tick();
    check("enable_rxEn", int'(rxEn), 1);
    m_ready = 1'b1;

    foreach (vecs[i]) begin
      push_expect(vecs[i]);
      send_vec(vecs[i]);
      wait_settle("vec_settle");
    end

    // Inter-byte timeout, then garbage before a clean packet.
    q_evt.push_back(10 + 3);
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    cnt = 0;
    while (q_evt.size() != 0 && cnt < 50000) begin
      tick();
      cnt++;
    end
    check("tmo_fired", q_evt.size(), 0);
    check("tmo_window", int'(cnt >= 43300 && cnt <= 43500), 1);
    q_evt.delete();
    q_dat.push_back(int'({1'b0, 8'h05}));
    q_dat.push_back(int'({1'b1, 8'h06}));
    q_evt.push_back(0);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h0D);
    wait_settle("post_tmo_settle");

    // Backpressure with m_ready toggling during the drain.
    m_ready = 1'b0;
    push_expect(vecs[7]);
    send_vec(vecs[7]);
    cnt = 0;
    while ((!rxEn || m_valid) && cnt < 60) begin
      m_ready = ~m_ready;
      tick();
      cnt++;
    end
    check("bp_settle", int'(rxEn && !m_valid), 1);
    m_ready = 1'b1;

    // Asynchronous reset in the middle of a payload.
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_rxEn", int'(rxEn), 0);
    check("async_reset_outs", int'({m_valid, m_last, pkt_ok, pkt_err, err_code, m_data}), 0);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    check("post_reset_rxEn", int'(rxEn), 1);
    push_expect(vecs[2]);
    send_vec(vecs[2]);
    wait_settle("post_reset_settle");

    // Enable dropped mid-payload; trailing bytes must be ignored.
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    enable = 1'b0;
    tick();
    check("abort_rxEn", int'(rxEn), 0);
    send_byte(8'h03);
    send_byte(8'h04);
    check("abort_hold_rxEn", int'(rxEn), 0);
    enable = 1'b1;
    tick();
    check("reenable_rxEn", int'(rxEn), 1);
    push_expect(vecs[0]);
    send_vec(vecs[0]);
    wait_settle("reenable_settle");

    repeat (5) tick();
    check("evt_queue_empty", q_evt.size(), 0);
    check("dat_queue_empty", q_dat.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
